// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl -- requesting side of the control unit's interrupt interface.
//
// Synchronises N_IRQ asynchronous request lines and latches each rising edge as
// a pending request. Tracks nested in-service interrupts. Presents the
// highest-priority (lowest index) enabled pending request and the
// highest-priority in-service interrupt as one-hot vectors, and the program
// address of the vector slot for the pending one.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   irq            in   raw peripheral request lines, rising-edge sensitive
//   s_intr         in   control-unit strobe: call and/or return this cycle
//   s_call_intr    in   one-hot line being entered (valid with s_intr)
//   s_return_intr  in   one-hot line being retired (valid with s_intr)
//   mask_we        in   mask register write enable
//   mask_in        in   new mask value, 1 = line enabled
//   clr_lost       in   clears the lost flags
//   min_bit_s      out  lowest set bit of pending & mask, 0 if none
//   min_bit_a      out  lowest set bit of in_service, 0 if none
//   vec_addr       out  vector slot address for min_bit_s
//   lost           out  sticky: an edge arrived while the line was pending
// -----------------------------------------------------------------------------
module intr_ctrl #(
  parameter int         N_IRQ      = 8,
  parameter logic [9:0] VEC_BASE   = 10'h3C0,
  parameter int         VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             s_intr,
  input  logic [N_IRQ-1:0] s_call_intr,
  input  logic [N_IRQ-1:0] s_return_intr,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             clr_lost,
  output logic [N_IRQ-1:0] min_bit_s,
  output logic [N_IRQ-1:0] min_bit_a,
  output logic [9:0]       vec_addr,
  output logic [N_IRQ-1:0] lost
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] sync0_q, sync0_d;
  logic [N_IRQ-1:0] sync1_q, sync1_d;
  logic [N_IRQ-1:0] prev_q, prev_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] lost_q, lost_d;

  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] call;
  logic [N_IRQ-1:0] ret;
  logic [N_IRQ-1:0] x_s;
  logic [IDX_W-1:0] idx;

  // Next-state logic.
  // NOTE: every signal driven here is assigned unconditionally so no latch can be inferred.
  always_comb begin
    // Two-flop synchroniser, then one more stage to remember the previous level.
    sync0_d  = irq;
    sync1_d  = sync0_q;
    prev_d   = sync1_q;
    edge_det = sync1_q & ~prev_q;

    call = s_intr ? s_call_intr   : '0;
    ret  = s_intr ? s_return_intr : '0;

    // A fresh edge on the line being called re-arms it: the new request wins.
    pending_d    = (pending_q & ~call) | edge_det;
    // Call wins over return on the same bit.
    in_service_d = (in_service_q & ~ret) | call;
    // Uses the pre-update pending; a loss seen in the clearing cycle survives.
    lost_d       = clr_lost ? (edge_det & pending_q)
                            : (lost_q | (edge_det & pending_q));
    mask_d       = mask_we ? mask_in : mask_q;
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q      <= '0;
      sync1_q      <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '1;
      lost_q       <= '0;
    end else begin
      sync0_q      <= sync0_d;
      sync1_q      <= sync1_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      lost_q       <= lost_d;
    end
  end

  // Outputs depend on registers only, never directly on inputs.
  always_comb begin
    x_s       = pending_q & mask_q;
    // Two's-complement trick isolates the lowest set bit.
    min_bit_s = x_s & (~x_s + N_IRQ'(1));
    min_bit_a = in_service_q & (~in_service_q + N_IRQ'(1));

    idx = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (min_bit_s[i]) idx = IDX_W'(i);
    end
    vec_addr = VEC_BASE + 10'(idx) * 10'(VEC_STRIDE);
    lost     = lost_q;
  end

endmodule
